// File: rtl/ethernet_pkg.sv
// Shared definitions for the Ethernet receive controller: FSM encoding,
// preamble/SFD nibble values and the frame length width.
package ethernet_pkg;

    localparam int         FRAME_LEN_W  = 11;
    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_LOW_NIB  = 3'd2,
        ST_HIGH_NIB = 3'd3,
        ST_FLUSH    = 3'd4,
        ST_DROP     = 3'd5
    } rx_state_e;

    function automatic logic [FRAME_LEN_W-1:0] len_sat_inc(input logic [FRAME_LEN_W-1:0] v);
        if (v == {FRAME_LEN_W{1'b1}}) begin
            return v;
        end else begin
            return v + FRAME_LEN_W'(1);
        end
    endfunction

endpackage

// File: rtl/ethernet_nib2byte.sv
// Nibble-to-byte assembler with a one-entry output register. A completed byte
// is exposed only once the next nibble or end of frame shows whether it is last.
module ethernet_nib2byte
    import ethernet_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       low_we_i,
    input  logic       high_we_i,
    input  logic       show_i,
    input  logic       last_i,
    input  logic [3:0] nib_i,
    input  logic       byte_ready_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_last_o,
    output logic       full_o,
    output logic       can_load_o
);

    logic [3:0] low_q,  low_d;
    logic [7:0] data_q, data_d;
    logic       full_q, full_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       accept_s;

    assign accept_s   = valid_q & byte_ready_i;
    assign can_load_o = ~full_q | accept_s;

    // Entry update; a byte loaded in the same cycle the old one is accepted replaces it
    always_comb begin
        low_d   = low_q;
        data_d  = data_q;
        full_d  = full_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (low_we_i) begin
            low_d = nib_i;
        end else begin
            low_d = low_q;
        end
        if (clr_i) begin
            full_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (high_we_i) begin
            data_d  = {nib_i, low_q};
            full_d  = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (accept_s) begin
            full_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (show_i && full_q && !valid_q) begin
            valid_d = 1'b1;
            last_d  = last_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            low_q   <= 4'h0;
            data_q  <= 8'h00;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            low_q   <= low_d;
            data_q  <= data_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;
    assign byte_last_o  = last_q;
    assign full_o       = full_q;

endmodule

// File: rtl/ethernet_rx_ctrl.sv
// Ethernet receive controller: synchronises rx_dv, tracks preamble/SFD, frames
// the payload bytes and reports frame length and error at the end of each frame.
module ethernet_rx_ctrl
    import ethernet_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_PRE = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    output logic        rx_start_o,
    input  logic        nib_ready_i,
    input  logic [3:0]  nib_i,
    input  logic        rx_dv_i,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic [7:0]  byte_data_o,
    output logic        byte_last_o,
    output logic        frame_done_o,
    output logic [10:0] frame_len_o,
    output logic        frame_err_o
);

    rx_state_e               state_q, state_d;
    logic [3:0]              pre_cnt_q, pre_cnt_d;
    logic [FRAME_LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic                    flush_err_q, flush_err_d;
    logic                    rx_start_q, rx_start_d;
    logic                    done_q, done_d;
    logic [FRAME_LEN_W-1:0]  len_q, len_d;
    logic                    err_q, err_d;

    logic       dv_meta_q, dv_sync_q, dv_prev_q;
    logic [1:0] warm_q;
    logic       armed_q;
    logic       dv_rise_s, dv_fall_s;

    logic clr_s, low_we_s, high_we_s, show_s, last_s;
    logic full_s, can_load_s;

    // A rise only counts once dv has been seen low after reset, so a frame in flight at release is skipped
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dv_meta_q <= 1'b0;
            dv_sync_q <= 1'b0;
            dv_prev_q <= 1'b0;
            warm_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            dv_meta_q <= rx_dv_i;
            dv_sync_q <= dv_meta_q;
            dv_prev_q <= dv_sync_q;
            warm_q    <= {warm_q[0], 1'b1};
            armed_q   <= armed_q | (warm_q[1] & ~dv_sync_q);
        end
    end

    assign dv_rise_s = dv_sync_q & ~dv_prev_q & armed_q;
    assign dv_fall_s = ~dv_sync_q & dv_prev_q;

    // Next-state, counters and assembler controls
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        flush_err_d = flush_err_q;
        rx_start_d  = 1'b0;
        done_d      = 1'b0;
        len_d       = {FRAME_LEN_W{1'b0}};
        err_d       = 1'b0;
        clr_s       = 1'b0;
        low_we_s    = 1'b0;
        high_we_s   = 1'b0;
        show_s      = 1'b0;
        last_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && dv_rise_s) begin
                    state_d    = ST_PREAMBLE;
                    pre_cnt_d  = 4'h0;
                    byte_cnt_d = {FRAME_LEN_W{1'b0}};
                    rx_start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (dv_fall_s) begin
                    state_d = ST_IDLE;
                end else if (nib_ready_i) begin
                    if (nib_i == PREAMBLE_NIB) begin
                        pre_cnt_d = (pre_cnt_q == 4'hF) ? 4'hF : pre_cnt_q + 4'd1;
                    end else if (nib_i == SFD_NIB && pre_cnt_q >= 4'(MIN_PRE)) begin
                        state_d    = ST_LOW_NIB;
                        byte_cnt_d = {FRAME_LEN_W{1'b0}};
                    end else begin
                        state_d = ST_DROP;
                        clr_s   = 1'b1;
                    end
                end else begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_LOW_NIB: begin
                if (dv_fall_s) begin
                    state_d     = ST_FLUSH;
                    flush_err_d = (byte_cnt_q == {FRAME_LEN_W{1'b0}});
                    show_s      = 1'b1;
                    last_s      = 1'b1;
                end else if (nib_ready_i) begin
                    state_d  = ST_HIGH_NIB;
                    low_we_s = 1'b1;
                    show_s   = 1'b1;
                end else begin
                    state_d = ST_LOW_NIB;
                end
            end
            ST_HIGH_NIB: begin
                if (dv_fall_s) begin
                    state_d     = ST_FLUSH;
                    flush_err_d = 1'b1;
                end else if (nib_ready_i) begin
                    if (byte_cnt_q >= FRAME_LEN_W'(MAX_LEN) || !can_load_s) begin
                        state_d = ST_DROP;
                        clr_s   = 1'b1;
                    end else begin
                        state_d    = ST_LOW_NIB;
                        high_we_s  = 1'b1;
                        byte_cnt_d = len_sat_inc(byte_cnt_q);
                    end
                end else begin
                    state_d = ST_HIGH_NIB;
                end
            end
            ST_FLUSH: begin
                if (!full_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    len_d   = byte_cnt_q;
                    err_d   = flush_err_q;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DROP: begin
                clr_s = 1'b1;
                if (!dv_sync_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    len_d   = byte_cnt_q;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            pre_cnt_q   <= 4'h0;
            byte_cnt_q  <= {FRAME_LEN_W{1'b0}};
            flush_err_q <= 1'b0;
            rx_start_q  <= 1'b0;
            done_q      <= 1'b0;
            len_q       <= {FRAME_LEN_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            flush_err_q <= flush_err_d;
            rx_start_q  <= rx_start_d;
            done_q      <= done_d;
            len_q       <= len_d;
            err_q       <= err_d;
        end
    end

    ethernet_nib2byte u_nib2byte (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clr_i        (clr_s),
        .low_we_i     (low_we_s),
        .high_we_i    (high_we_s),
        .show_i       (show_s),
        .last_i       (last_s),
        .nib_i        (nib_i),
        .byte_ready_i (byte_ready_i),
        .byte_valid_o (byte_valid_o),
        .byte_data_o  (byte_data_o),
        .byte_last_o  (byte_last_o),
        .full_o       (full_s),
        .can_load_o   (can_load_s)
    );

    assign rx_start_o   = rx_start_q;
    assign frame_done_o = done_q;
    assign frame_len_o  = len_q;
    assign frame_err_o  = err_q;

endmodule

// File: tb/tb_ethernet_rx_ctrl.sv
// Directed bench for ethernet_rx_ctrl: a default instance and a MAX_LEN=4
// instance share stimulus; a negedge monitor logs accepted bytes and frame ends.
module tb_ethernet_rx_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       nib_ready;
    logic [3:0] nib;
    logic       rx_dv;
    logic       byte_ready;

    logic        rx_start_a, byte_valid_a, byte_last_a, frame_done_a, frame_err_a;
    logic [7:0]  byte_data_a;
    logic [10:0] frame_len_a;
    logic        rx_start_b, byte_valid_b, byte_last_b, frame_done_b, frame_err_b;
    logic [7:0]  byte_data_b;
    logic [10:0] frame_len_b;

    int n_checks = 0;
    int n_err    = 0;

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    int done_a = 0, done_b = 0, start_a = 0;
    logic [10:0] len_a = 11'd0, len_b = 11'd0;
    logic err_a = 1'b0, err_b = 1'b0;

    int ba, bb, da, db, sa;

    ethernet_rx_ctrl dut_a (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .rx_start_o(rx_start_a),
        .nib_ready_i(nib_ready), .nib_i(nib), .rx_dv_i(rx_dv),
        .byte_valid_o(byte_valid_a), .byte_ready_i(byte_ready), .byte_data_o(byte_data_a),
        .byte_last_o(byte_last_a), .frame_done_o(frame_done_a), .frame_len_o(frame_len_a),
        .frame_err_o(frame_err_a)
    );

    ethernet_rx_ctrl #(.MAX_LEN(4), .MIN_PRE(8)) dut_b (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .rx_start_o(rx_start_b),
        .nib_ready_i(nib_ready), .nib_i(nib), .rx_dv_i(rx_dv),
        .byte_valid_o(byte_valid_b), .byte_ready_i(byte_ready), .byte_data_o(byte_data_b),
        .byte_last_o(byte_last_b), .frame_done_o(frame_done_b), .frame_len_o(frame_len_b),
        .frame_err_o(frame_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes are decided by values stable at the falling edge
    always @(negedge clk) begin
        if (byte_valid_a && byte_ready) q_a.push_back({byte_last_a, byte_data_a});
        if (byte_valid_b && byte_ready) q_b.push_back({byte_last_b, byte_data_b});
        if (frame_done_a) begin done_a++; len_a = frame_len_a; err_a = frame_err_a; end
        if (frame_done_b) begin done_b++; len_b = frame_len_b; err_b = frame_err_b; end
        if (rx_start_a) start_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] v);
        nib = v;
        nib_ready = 1'b1;
        cyc(1);
        nib_ready = 1'b0;
        cyc(2);
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) send_nib(4'h5);
        send_nib(4'hD);
    endtask

    task automatic send_data(input int n);
        for (int i = 0; i < n; i++) send_nib(4'(i + 1));
    endtask

    task automatic dv_up();
        rx_dv = 1'b1;
        cyc(4);
    endtask

    task automatic dv_down();
        rx_dv = 1'b0;
        cyc(20);
    endtask

    task automatic mark();
        ba = q_a.size(); bb = q_b.size(); da = done_a; db = done_b; sa = start_a;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; nib_ready = 1'b0; nib = 4'h0;
        rx_dv = 1'b0; byte_ready = 1'b1;
        cyc(3);
        chk("rst_valid", 32'(byte_valid_a), 32'h0);
        chk("rst_data", 32'(byte_data_a), 32'h0);
        chk("rst_start", 32'(rx_start_a), 32'h0);
        chk("rst_done", 32'(frame_done_a), 32'h0);
        reset = 1'b0; enable = 1'b1;
        cyc(5);

        // two-byte frame, consumer always ready
        mark();
        dv_up(); send_pre(16); send_data(4); dv_down();
        chk("f1_start", 32'(start_a), 32'(sa + 1));
        chk("f1_nbytes", 32'(q_a.size()), 32'(ba + 2));
        chk("f1_byte0", 32'(q_a[ba]), 32'h021);
        chk("f1_byte1", 32'(q_a[ba + 1]), 32'h143);
        chk("f1_done", 32'(done_a), 32'(da + 1));
        chk("f1_len", 32'(len_a), 32'd2);
        chk("f1_err", 32'(err_a), 32'h0);

        // short preamble
        mark();
        dv_up(); send_pre(4); send_data(4); dv_down();
        chk("pre_nbytes", 32'(q_a.size()), 32'(ba));
        chk("pre_done", 32'(done_a), 32'(da + 1));
        chk("pre_len", 32'(len_a), 32'd0);
        chk("pre_err", 32'(err_a), 32'h1);

        // stalled consumer: overflow on second completion
        mark();
        byte_ready = 1'b0;
        dv_up(); send_pre(8); send_data(3);
        chk("ovf_held_valid", 32'(byte_valid_a), 32'h1);
        chk("ovf_held_data", 32'(byte_data_a), 32'h21);
        send_nib(4'h4);
        chk("ovf_valid_drop", 32'(byte_valid_a), 32'h0);
        send_nib(4'h5); send_nib(4'h6); dv_down();
        byte_ready = 1'b1;
        cyc(2);
        chk("ovf_nbytes", 32'(q_a.size()), 32'(ba));
        chk("ovf_done", 32'(done_a), 32'(da + 1));
        chk("ovf_len", 32'(len_a), 32'd1);
        chk("ovf_err", 32'(err_a), 32'h1);

        // odd nibble count; enable dropped mid-frame must not abort
        mark();
        dv_up(); send_pre(8); enable = 1'b0; send_data(5); dv_down();
        chk("odd_nbytes", 32'(q_a.size()), 32'(ba + 2));
        chk("odd_byte1", 32'(q_a[ba + 1]), 32'h043);
        chk("odd_done", 32'(done_a), 32'(da + 1));
        chk("odd_len", 32'(len_a), 32'd2);
        chk("odd_err", 32'(err_a), 32'h1);

        // enable low blocks a new frame
        mark();
        dv_up(); send_pre(8); send_data(4); dv_down();
        chk("dis_start", 32'(start_a), 32'(sa));
        chk("dis_done", 32'(done_a), 32'(da));
        chk("dis_nbytes", 32'(q_a.size()), 32'(ba));
        enable = 1'b1;

        // six-byte frame: MAX_LEN=4 instance drops after four bytes
        mark();
        dv_up(); send_pre(8); send_data(12); dv_down();
        chk("max_b_nbytes", 32'(q_b.size()), 32'(bb + 4));
        chk("max_b_byte3", 32'(q_b[bb + 3]), 32'h087);
        chk("max_b_done", 32'(done_b), 32'(db + 1));
        chk("max_b_len", 32'(len_b), 32'd4);
        chk("max_b_err", 32'(err_b), 32'h1);
        chk("max_a_nbytes", 32'(q_a.size()), 32'(ba + 6));
        chk("max_a_byte5", 32'(q_a[ba + 5]), 32'h1CB);
        chk("max_a_len", 32'(len_a), 32'd6);
        chk("max_a_err", 32'(err_a), 32'h0);

        // reset mid-payload with dv still high
        dv_up(); send_pre(8); send_data(3);
        mark();
        reset = 1'b1;
        cyc(2);
        chk("mrst_valid", 32'(byte_valid_a), 32'h0);
        chk("mrst_data", 32'(byte_data_a), 32'h0);
        chk("mrst_last", 32'(byte_last_a), 32'h0);
        chk("mrst_len", 32'(frame_len_a), 32'h0);
        chk("mrst_err", 32'(frame_err_a), 32'h0);
        reset = 1'b0;
        cyc(6);
        send_data(6);
        dv_down();
        chk("mrst_no_done", 32'(done_a), 32'(da));
        chk("mrst_no_start", 32'(start_a), 32'(sa));

        mark();
        dv_up(); send_pre(8); send_data(4); dv_down();
        chk("post_nbytes", 32'(q_a.size()), 32'(ba + 2));
        chk("post_byte0", 32'(q_a[ba]), 32'h021);
        chk("post_byte1", 32'(q_a[ba + 1]), 32'h143);
        chk("post_done", 32'(done_a), 32'(da + 1));
        chk("post_len", 32'(len_a), 32'd2);
        chk("post_err", 32'(err_a), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ethernet_rx_ctrl.md
ETHERNET_RX_CTRL -- requirements
Module: ethernet_rx_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, maximum accepted frame length in bytes (SFD excluded).
REQ-002 SHALL have parameter MIN_PRE, default 8, minimum count of 0x5 preamble nibbles before SFD.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  level; 1 = accept new frames.
REQ-006 rx_start  output  1  drives the nibble receiver's start input.
REQ-007 nib_ready  input  1  one-cycle pulse from receiver: new nibble valid.
REQ-008 nib  input  4  received nibble, valid with nib_ready.
REQ-009 rx_dv  input  1  PHY data-valid, asynchronous to clk.
REQ-010 byte_valid  output  1  assembled byte available.
REQ-011 byte_ready  input  1  consumer accepts byte when byte_valid & byte_ready.
REQ-012 byte_data  output  8  assembled byte.
REQ-013 byte_last  output  1  marks final byte of frame, valid with byte_valid.
REQ-014 frame_done  output  1  one-cycle pulse at end of each accepted or dropped frame.
REQ-015 frame_len  output  11  byte count of the frame, valid with frame_done.
REQ-016 frame_err  output  1  valid with frame_done: 1 = frame dropped/truncated.

Function
REQ-017 rx_dv SHALL pass through a 2-flop synchronizer; "dv" below means the synchronized value.
REQ-018 rx_start SHALL be a one-cycle pulse on leaving IDLE, and 0 otherwise.
REQ-019 States: IDLE, PREAMBLE, LOW_NIB, HIGH_NIB, FLUSH, DROP.
REQ-020 IDLE -> PREAMBLE when enable=1 and dv rises (0 then 1); preamble counter cleared.
REQ-021 PREAMBLE: each nib_ready with nib=0x5 increments a saturating 4-bit counter.
REQ-022 PREAMBLE: nib=0xD with counter >= MIN_PRE -> LOW_NIB; byte counter cleared.
REQ-023 PREAMBLE: any other nibble, or 0xD with counter < MIN_PRE -> DROP.
REQ-024 PREAMBLE: dv falls before SFD -> IDLE, no frame_done.
REQ-025 LOW_NIB: nib_ready stores nib in byte bits [3:0] -> HIGH_NIB.
REQ-026 HIGH_NIB: nib_ready completes byte {nib, low} into the output register, sets byte_valid, increments byte counter -> LOW_NIB.
REQ-027 byte_valid SHALL hold with stable byte_data until accepted; output register is one entry deep.
REQ-028 Byte completing while byte_valid=1 and byte_ready=0 in the same cycle -> overflow -> DROP with frame_err.
REQ-029 Byte completing in the same cycle an existing byte is accepted SHALL be loaded, not an overflow.
REQ-030 Byte counter reaching MAX_LEN and another byte completing -> DROP with frame_err.
REQ-031 dv falls in LOW_NIB -> FLUSH; byte_last asserted on the pending/next byte; frame_err=0.
REQ-032 dv falls in HIGH_NIB (odd nibble) -> FLUSH, half byte discarded, frame_err=1.
REQ-033 dv falls with zero bytes received -> frame_done, frame_len=0, frame_err=1, no byte.
REQ-034 FLUSH: when last byte accepted (or none pending) pulse frame_done with frame_len = byte counter -> IDLE.
REQ-035 DROP: ignore nibbles, clear byte_valid at once, wait for dv low, then pulse frame_done, frame_err=1 -> IDLE.
REQ-036 enable deasserted mid-frame SHALL NOT abort the current frame; only blocks the next.
REQ-037 Byte counter SHALL saturate at 2047; frame_len reports count at the terminating event.

Reset
REQ-038 reset SHALL force state IDLE, synchronizer flops 0, counters 0, byte_data 0x00, and all outputs 0.
REQ-039 reset mid-frame SHALL discard the frame with no frame_done after release.
REQ-040 After release, a frame already in progress (dv=1) SHALL be ignored until dv falls and rises again.

Structure
REQ-041 Shared package ethernet_pkg SHALL hold state encoding, PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, and frame length width.
REQ-042 Nibble-to-byte assembly with output register SHALL be sub-module ethernet_nib2byte; FSM and counters stay in top.

Verification
REQ-043 16x0x5, 0xD, nibbles 1,2,3,4, dv low, byte_ready=1 -> bytes 0x21,0x43 (last on 0x43); frame_done, len=2, err=0.
REQ-044 Preamble 4x0x5 then 0xD with MIN_PRE=8 -> no bytes, frame_done err=1 len=0 after dv low.
REQ-045 Valid 3-byte frame with byte_ready=0 throughout -> first byte held, second completion overflows, byte_valid drops, frame_done err=1.
REQ-046 Valid frame with 5 nibbles of data -> 2 bytes output, frame_done len=2 err=1.
REQ-047 MAX_LEN=4, 6-byte frame -> 4 bytes, DROP, frame_done err=1 len=4.
REQ-048 reset pulse mid-payload, dv still high -> all outputs 0, no frame_done; next full frame received correctly.
